// File: rtl/image_draw.sv
// image_draw: overlays a 48x64 ROM image onto the VGA pixel stream at a vsync-latched (x,y)
//   clk, rst                      pixel clock, asynchronous active-high reset
//   hcount_in..rgb_in             incoming timing and background colour
//   xpos, ypos                    requested image position, sampled on vsync rising edge
//   pixel_addr, rom_rgb           ROM address {y[5:0],x[5:0]} and its data one clk later
//   hcount_out..rgb_out           timing and composited colour, 3 clk behind the inputs
module image_draw #(
  parameter int IMG_W = 48,
  parameter int IMG_H = 64,
  parameter bit KEY_EN = 1'b1,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] pixel_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  logic        vs_prev_q;
  logic [11:0] x_lat_q, y_lat_q, x_lat_d, y_lat_d;
  logic [11:0] pixel_addr_q, pixel_addr_d;
  logic [12:0] hc, vc, xl, yl;
  logic        in_win, rise, key_hit;
  logic        win_d1_q, win_d2_q;
  logic [37:0] t_in, t_d1_q, t_d2_q, out_q, out_d;
  always_comb begin
    hc = {2'b00, hcount_in};
    vc = {2'b00, vcount_in};
    xl = {1'b0, x_lat_q};
    yl = {1'b0, y_lat_q};
    // 13-bit compares: an image beyond the counter range is clipped, never wrapped
    in_win = (hc >= xl) && (hc < xl + 13'(IMG_W)) && (vc >= yl) && (vc < yl + 13'(IMG_H))
             && !hblnk_in && !vblnk_in;
    // low 6 bits of the difference depend only on the low 6 bits of the operands
    pixel_addr_d = in_win ? {vcount_in[5:0] - y_lat_q[5:0], hcount_in[5:0] - x_lat_q[5:0]} : pixel_addr_q;
    rise = vsync_in && !vs_prev_q;
    x_lat_d = rise ? xpos : x_lat_q;
    y_lat_d = rise ? ypos : y_lat_q;
    t_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
    key_hit = KEY_EN && (rom_rgb == KEY_COLOR);
    // rom_rgb lines up with win_d2: address issued at edge 1, ROM registers it at edge 2
    out_d = {t_d2_q[37:12], (win_d2_q && !key_hit) ? rom_rgb : t_d2_q[11:0]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q <= 1'b0;
      x_lat_q <= '0;
      y_lat_q <= '0;
      pixel_addr_q <= '0;
      win_d1_q <= 1'b0;
      win_d2_q <= 1'b0;
      t_d1_q <= '0;
      t_d2_q <= '0;
      out_q <= '0;
    end else begin
      vs_prev_q <= vsync_in;
      x_lat_q <= x_lat_d;
      y_lat_q <= y_lat_d;
      pixel_addr_q <= pixel_addr_d;
      win_d1_q <= in_win;
      win_d2_q <= win_d1_q;
      t_d1_q <= t_in;
      t_d2_q <= t_d1_q;
      out_q <= out_d;
    end
  end
  assign pixel_addr = pixel_addr_q;
  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} = out_q;
endmodule

// File: tb/tb_image_draw.sv
// tb_image_draw: randomized and directed check of image_draw against a behavioural model
module tb_image_draw;
  logic        clk = 1'b0, rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0, xpos = '0, ypos = '0;
  logic [11:0] pixel_addr, rom_rgb, pixel_addr_nk, rom_rgb_nk;
  logic [10:0] hcount_out, vcount_out, hcount_out_nk, vcount_out_nk;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic        hsync_out_nk, vsync_out_nk, hblnk_out_nk, vblnk_out_nk;
  logic [11:0] rgb_out, rgb_out_nk;
  logic [11:0] mem [4096];
  int checks = 0, errors = 0;
  typedef struct {
    logic [25:0] tim;
    logic [11:0] rgb;
    logic [11:0] rgb_nk;
  } ent_t;
  ent_t q[$];
  int xl, yl;
  bit pv;
  logic [11:0] ea;
  always #5 clk = ~clk;
  image_draw dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .pixel_addr(pixel_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );
  image_draw #(.KEY_EN(1'b0)) dut_nk (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .pixel_addr(pixel_addr_nk), .rom_rgb(rom_rgb_nk),
    .hcount_out(hcount_out_nk), .vcount_out(vcount_out_nk), .hsync_out(hsync_out_nk),
    .vsync_out(vsync_out_nk), .hblnk_out(hblnk_out_nk), .vblnk_out(vblnk_out_nk), .rgb_out(rgb_out_nk)
  );
  always @(posedge clk) begin
    rom_rgb <= mem[pixel_addr];
    rom_rgb_nk <= mem[pixel_addr_nk];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    ent_t z;
    z.tim = '0;
    z.rgb = '0;
    z.rgb_nk = '0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
    xl = 0;
    yl = 0;
    pv = 1'b0;
    ea = '0;
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {6'b0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 32'd0);
    chk(tag, {8'b0, rgb_out, pixel_addr}, 32'd0);
  endtask
  task automatic cycle();
    ent_t e;
    bit win;
    logic [11:0] a, m;
    int h, v;
    h = int'(hcount_in);
    v = int'(vcount_in);
    win = h >= xl && h < xl + 48 && v >= yl && v < yl + 64 && !hblnk_in && !vblnk_in;
    a = {6'(v - yl), 6'(h - xl)};
    m = mem[a];
    e.tim = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    e.rgb = (win && m != 12'hF0F) ? m : rgb_in;
    e.rgb_nk = win ? m : rgb_in;
    if (win) ea = a;
    if (vsync_in && !pv) begin
      xl = int'(xpos);
      yl = int'(ypos);
    end
    pv = vsync_in;
    @(posedge clk);
    #1;
    q.push_back(e);
    chk("pixel_addr", {20'b0, pixel_addr}, {20'b0, ea});
    if (q.size() == 3) begin
      chk("timing", {6'b0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, {6'b0, q[0].tim});
      chk("timing_nk", {6'b0, hcount_out_nk, vcount_out_nk, hsync_out_nk, vsync_out_nk, hblnk_out_nk, vblnk_out_nk}, {6'b0, q[0].tim});
      chk("rgb", {20'b0, rgb_out}, {20'b0, q[0].rgb});
      chk("rgb_nk", {20'b0, rgb_out_nk}, {20'b0, q[0].rgb_nk});
      void'(q.pop_front());
    end else begin
      chk("queue_depth", q.size(), 3);
    end
  endtask
  task automatic set_px(input int h, input int v, input logic [11:0] c);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    hblnk_in = 1'b0;
    vblnk_in = 1'b0;
    rgb_in = c;
  endtask
  task automatic vs_latch(input int x, input int y);
    set_px(0, 0, 12'h000);
    cycle();
    xpos = 12'(x);
    ypos = 12'(y);
    vsync_in = 1'b1;
    cycle();
    vsync_in = 1'b0;
    cycle();
  endtask
  task automatic rand_cycle();
    int h, v;
    h = (xl > 2047) ? int'($urandom_range(0, 2047)) : xl + int'($urandom_range(0, 60)) - 6;
    v = (yl > 2047) ? int'($urandom_range(0, 2047)) : yl + int'($urandom_range(0, 76)) - 6;
    hcount_in = 11'(h < 0 ? 0 : h > 2047 ? 2047 : h);
    vcount_in = 11'(v < 0 ? 0 : v > 2047 ? 2047 : v);
    hsync_in = ($urandom_range(0, 9) == 0);
    vsync_in = ($urandom_range(0, 49) == 0);
    hblnk_in = ($urandom_range(0, 9) == 0);
    vblnk_in = ($urandom_range(0, 19) == 0);
    rgb_in = 12'($urandom);
    case ($urandom_range(0, 3))
      0: xpos = 12'($urandom);
      1: xpos = 12'($urandom_range(2030, 2047));
      default: xpos = 12'($urandom_range(0, 700));
    endcase
    ypos = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 500));
    cycle();
  endtask
  initial begin
    for (int i = 0; i < 4096; i++)
      mem[i] = ($urandom_range(0, 5) == 0) ? 12'hF0F : 12'($urandom);
    mem[12'h000] = 12'hF0F;
    mem[12'h001] = 12'h0A5;
    #1;
    chk_zero("reset_async");
    @(posedge clk);
    #1;
    chk_zero("reset_hold");
    rst = 1'b0;
    model_reset();
    set_px(10, 10, 12'h123);
    cycle();
    chk("lat_zero_addr", {20'b0, pixel_addr}, {20'b0, 6'd10, 6'd10});
    set_px(0, 0, 12'h000);
    hsync_in = 1'b1;
    hblnk_in = 1'b1;
    vblnk_in = 1'b1;
    repeat (3) cycle();
    set_px(0, 0, 12'h000);
    vcount_in = 11'd77;
    repeat (4) cycle();
    vs_latch(100, 50);
    set_px(100, 50, 12'h321);
    cycle();
    chk("place_origin", {20'b0, pixel_addr}, 32'h000);
    set_px(101, 50, 12'h456);
    cycle();
    chk("place_0a5", {20'b0, pixel_addr}, 32'h001);
    set_px(147, 113, 12'h789);
    cycle();
    chk("place_corner", {20'b0, pixel_addr}, {20'b0, 6'd63, 6'd47});
    set_px(148, 113, 12'hABC);
    cycle();
    set_px(120, 70, 12'hDEF);
    hblnk_in = 1'b1;
    cycle();
    repeat (3) cycle();
    set_px(100, 60, 12'h111);
    xpos = 12'd200;
    cycle();
    chk("frame_sync_old", {20'b0, pixel_addr}, {20'b0, 6'd10, 6'd0});
    set_px(205, 60, 12'h222);
    cycle();
    chk("frame_sync_hold", {20'b0, pixel_addr}, {20'b0, 6'd10, 6'd0});
    vs_latch(200, 50);
    set_px(205, 60, 12'h333);
    cycle();
    chk("frame_sync_new", {20'b0, pixel_addr}, {20'b0, 6'd10, 6'd5});
    vs_latch(620, 0);
    for (int h = 600; h < 640; h++) begin
      set_px(h, 5, 12'(h));
      cycle();
    end
    for (int h = 0; h < 28; h++) begin
      set_px(h, 6, 12'(h + 1));
      cycle();
    end
    for (int i = 0; i < 3000; i++) rand_cycle();
    #2;
    rst = 1'b1;
    #1;
    chk_zero("reset_mid_async");
    @(posedge clk);
    #1;
    chk_zero("reset_mid_hold");
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 200; i++) rand_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/image_draw.md
Name: image_draw

Overview:
- Pixel-stream stage that reads the 48x64 image ROM and overlays the image onto the VGA timing/colour stream at a movable (x,y) position.
- Sits between the background/timing generator and the VGA output register stage.
- Acts as the ROM reader: generates the 12-bit {y[5:0],x[5:0]} address and absorbs the ROM's one-cycle synchronous read latency.
- Delays all timing signals so that sync, blanking and colour remain aligned.

Parameters:
- IMG_W, 48, image width in pixels (x coordinate range 0..IMG_W-1, at most 64).
- IMG_H, 64, image height in pixels (y coordinate range 0..IMG_H-1, at most 64).
- KEY_EN, 1, when 1, ROM pixels equal to KEY_COLOR are transparent.
- KEY_COLOR, 12'hF0F, transparent colour key.

Ports:
- clk  in  1  pixel clock; every register is clocked on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- hcount_in  in  11  horizontal pixel counter.
- vcount_in  in  11  vertical line counter.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- hblnk_in  in  1  horizontal blanking.
- vblnk_in  in  1  vertical blanking.
- rgb_in  in  12  background colour {r,g,b}.
- xpos  in  12  requested image left edge.
- ypos  in  12  requested image top edge.
- pixel_addr  out  12  ROM address {y[5:0],x[5:0]}.
- rom_rgb  in  12  ROM data; valid one clk after pixel_addr.
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  timing signals delayed by 3 clk.
- rgb_out  out  12  composited colour, delayed by 3 clk.

Behaviour:
Reset and position latch
- Reset: all outputs, pipeline registers, latched position and the vsync edge register go to 0 asynchronously.
- After reset is released, outputs are invalid until the pipeline refills (3 clk).
- Reset mid-frame: the pipeline is cleared and resumes with the next input sample; no other recovery is needed.
- Position latch: x_lat/y_lat load xpos/ypos on the clk in which vsync_in is 1 and its previous sampled value was 0 (rising edge).
- Position changes within a frame never take effect mid-frame, so there is no tearing.
- If xpos changes in the same cycle as the vsync rising edge, the new value is latched.

Window and address (stage 0, combinational)
- in_win = (hcount_in >= x_lat) and (hcount_in < x_lat+IMG_W) and (vcount_in >= y_lat) and (vcount_in < y_lat+IMG_H) and not hblnk_in and not vblnk_in.
- Comparisons use 13-bit unsigned arithmetic. There is no wrap-around: an image placed partly beyond the counter range is clipped, and x_lat >= 2048 never matches.
- rel_x = hcount_in - x_lat and rel_y = vcount_in - y_lat; the low 6 bits of each are used.

Pipeline
- Stage 1 (clk edge 1):
  - pixel_addr <= {rel_y[5:0], rel_x[5:0]} when in_win, else pixel_addr holds its previous value.
  - win_d1 <= in_win.
  - Timing and rgb_in are registered as d1.
- Stage 2 (edge 2):
  - The ROM registers rom_rgb.
  - win_d2, timing d2 and rgb d2 are registered.
- Stage 3 (edge 3):
  - Timing outputs <= d2.
  - rgb_out <= rom_rgb when win_d2 and not (KEY_EN and rom_rgb == KEY_COLOR); otherwise rgb_out <= rgb d2.
- Total latency from input to output is exactly 3 clk for every signal.
- Blanking overrides the window: pixels inside the image area but in blanking pass rgb_in through unchanged (normally 0).

Test Plan:
- Reset: assert rst mid-stream -> all outputs are 0 immediately (asynchronously) and after release; latched position is 0.
- Latency: hsync_in pulse at cycle N -> hsync_out pulse at cycle N+3 with identical width; same check for hblnk, vblnk and vcount.
- Placement, with xpos=100, ypos=50 latched at vsync:
  - hcount=100, vcount=50 -> pixel_addr=12'h000 one clk later.
  - hcount=147, vcount=113 -> pixel_addr={6'd63,6'd47}.
  - hcount=148 -> rgb_out=rgb_in.
- Colour key: ROM stub returns 12'hF0F at an in-window pixel -> rgb_out=rgb_in. Returns 12'h0A5 -> rgb_out=12'h0A5. With KEY_EN=0, 12'hF0F is drawn.
- Frame sync: change xpos from 100 to 200 mid-frame -> image remains at x=100 until the next vsync rising edge, then is drawn at x=200.
- Clipping: xpos=620 on a 640-wide display -> columns 0..19 are drawn; no artefacts appear at hcount 0..27 of the next line.
